pfiform_pop_serializer: RTL and testbench
=========================================

Name: pfiform_pop_serializer

Overview:
- Consumer stage directly downstream of the PFIFORM join/pop FIFO.
- Accepts 256-bit PopData words, each carrying PopAmout valid bytes (0..31), under the PopEnable/PopPermit handshake.
- Re-emits those bytes as a narrow valid/ready stream of OUT_BYTES bytes per beat, with a byte-enable mask and an end-of-word flag.
- A 2-entry input buffer decouples FIFO pops from output backpressure.

Parameters:
- OUT_BYTES, 4, bytes per output beat; legal values are 1, 2, 4, 8, 16, 32.
- BUF_DEPTH, 2, input buffer entries; fixed at 2 in this revision.

Ports:
- i_core_clk  in  1  core clock; all logic on rising edge.
- i_rx_rst  in  1  synchronous, active-high reset.
- PopEnable  in  1  upstream word valid.
- PopPermit  out  1  this block can accept a word this cycle.
- PopAmout  in  5  valid byte count of PopData, 0..31.
- PopData  in  256  word data; byte i = PopData[8i+7:8i].
- o_data  out  8*OUT_BYTES  output beat; byte j = o_data[8j+7:8j].
- o_byte_en  out  OUT_BYTES  per-byte valid mask of the current beat.
- o_valid  out  1  output beat valid.
- o_last  out  1  final beat of the current word.
- i_ready  in  1  downstream accepts the beat.
- o_ovf_err  out  1  sticky: a PopEnable arrived while PopPermit was low.
- o_byte_cnt  out  32  emitted-byte statistic (see Optional Feature).

Behaviour:
- Reset (i_rx_rst=1 at a clock edge):
  - All outputs go to 0, including PopPermit and o_ovf_err.
  - Buffer is emptied; any partially sent word is discarded.
  - First cycle after reset: PopPermit=1.
- Accept rule:
  - accept = PopEnable & PopPermit.
  - PopPermit = (occupancy < 2), decoded from registered occupancy only (no combinational path from i_ready).
  - On accept, store {PopAmout, PopData} at the buffer tail.
  - PopEnable with PopPermit=0: word dropped, o_ovf_err set to 1 until reset.
- Occupancy:
  - Accept and head release in the same cycle leave occupancy unchanged.
  - An accept at occupancy 1 with no release gives occupancy 2, and PopPermit=0 the next cycle.
- Serializer FSM:
  - IDLE:
    - Head entry present with amt>0: load beat index k=0 and go to SEND.
    - Head entry with amt=0: release the head in 1 cycle, emit no beat, stay in IDLE.
  - SEND:
    - Present o_data = bytes k*OUT_BYTES .. k*OUT_BYTES+OUT_BYTES-1 of the head word.
    - Byte j of o_byte_en = (k*OUT_BYTES + j < amt).
    - o_last = (k == ceil(amt/OUT_BYTES)-1).
    - On o_valid & i_ready: k increments. If o_last, release the head.
    - After release: if the next entry is present with amt>0, present its beat 0 the next cycle (no bubble); otherwise go to IDLE.
- Latency: word accepted at cycle T into an empty buffer → o_valid=1 at T+1.
- Output stability: while o_valid=1 and i_ready=0, o_data, o_byte_en and o_last hold stable. o_valid never drops without a handshake.
- Masking: bytes outside o_byte_en are driven 0. Byte 31 of PopData is never emitted, since amt ≤ 31.
- Beat count per word = ceil(amt/OUT_BYTES). With OUT_BYTES=32, every nonzero word is one beat with o_last=1.
- Arithmetic: k is wide enough for 32/OUT_BYTES beats. Compares use 6-bit unsigned values; no wrap.

Optional Feature:
- Macro: PFISER_STATS_EN
- Defined:
  - o_byte_cnt increments by popcount(o_byte_en) on each o_valid & i_ready.
  - It wraps modulo 2^32 and clears on reset.
- Undefined:
  - o_byte_cnt tied to 0; no counter logic synthesized.

Test Plan:
- OUT_BYTES=4, single word PopAmout=10, data bytes 0x00..0x1F, i_ready=1:
  - 3 beats: 0x03020100/1111, 0x07060504/1111, 0x00000908/0011 with o_last=1.
  - First o_valid one cycle after accept.
- Back-to-back PopAmout=23 then 15, i_ready=1: 6 beats then 4 beats, 10 consecutive valid cycles, o_last on beats 6 and 10, last masks 0111 and 0111.
- PopAmout=0 word between two 10-byte words: no beats for it, o_last count=2, PopPermit never stuck low.
- i_ready held 0 while 3 words offered with PopEnable every cycle:
  - 2 accepted, PopPermit=0, o_data stable.
  - Forcing a 3rd PopEnable sets o_ovf_err=1 and keeps it until reset.
- i_rx_rst=1 mid-word (after beat 1 of 3):
  - Next cycle all outputs 0 and buffer empty.
  - After release, PopPermit=1 and new words start at beat 0.
- PFISER_STATS_EN defined, words of 10, 23, 15 bytes → o_byte_cnt=48. Macro undefined → o_byte_cnt=0 throughout.

Source files
------------

// File: rtl/pfiform_pop_serializer_if.sv
// Signal bundle between the PFIFORM pop FIFO, pfiform_pop_serializer and its beat sink.
// slave = serializer view, master = FIFO/sink (or bench) view.
interface pfiform_pop_serializer_if #(
  parameter int OUT_BYTES = 4
);
  logic                   PopEnable;
  logic                   PopPermit;
  logic [4:0]             PopAmout;
  logic [255:0]           PopData;
  logic [8*OUT_BYTES-1:0] o_data;
  logic [OUT_BYTES-1:0]   o_byte_en;
  logic                   o_valid;
  logic                   o_last;
  logic                   i_ready;

  modport slave (
    input  PopEnable, PopAmout, PopData, i_ready,
    output PopPermit, o_data, o_byte_en, o_valid, o_last
  );

  modport master (
    output PopEnable, PopAmout, PopData, i_ready,
    input  PopPermit, o_data, o_byte_en, o_valid, o_last
  );
endinterface

// File: rtl/pfiform_pop_serializer.sv
// Splits 256-bit PFIFORM pop words into OUT_BYTES-wide beats through a 2-entry buffer.
// Optional emitted-byte counter on o_byte_cnt is enabled by defining PFISER_STATS_EN.
module pfiform_pop_serializer #(
  parameter int OUT_BYTES = 4,
  parameter int BUF_DEPTH = 2
) (
  input  logic                    i_core_clk,
  input  logic                    i_rx_rst,
  pfiform_pop_serializer_if.slave bus,
  output logic                    o_ovf_err,
  output logic [31:0]             o_byte_cnt
);
  localparam int NBEATS  = 32 / OUT_BYTES;
  localparam int KW      = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int OB_LOG2 = $clog2(OUT_BYTES);
  localparam int DW      = 8 * OUT_BYTES;

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [1:0]    occ_q, occ_d;
  logic          hd_q, hd_d;
  logic          permit_q;
  logic          ovf_q;
  logic [255:0]  data_q [2];
  logic [4:0]    amt_q  [2];

  logic [255:0]    head_data_s;
  logic [DW-1:0]   shifted_s;
  logic [4:0]      head_amt_s;
  logic [4:0]      nxt_amt_s;
  logic [5:0]      base_s;
  logic            valid_s, last_s, fire_s, accept_s, release_s, tail_s, nxt_go_s;
  logic [OUT_BYTES-1:0] be_s;
  logic [DW-1:0]   beat_s;

  assign head_data_s = data_q[hd_q];
  assign head_amt_s  = amt_q[hd_q];
  assign valid_s     = (state_q == S_SEND);
  assign fire_s      = valid_s & bus.i_ready;
  assign accept_s    = bus.PopEnable & permit_q;
  assign tail_s      = hd_q ^ occ_q[0];
  assign base_s      = 6'(k_q) << OB_LOG2;
  assign last_s      = ((base_s + 6'(OUT_BYTES)) >= {1'b0, head_amt_s});
  assign shifted_s   = DW'(head_data_s >> {base_s, 3'b000});

  // Head release: last beat handshaken, or an empty (amt=0) word skipped while idle
  always_comb begin
    release_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((occ_q != 2'd0) && (head_amt_s == 5'd0)) release_s = 1'b1;
        else                                         release_s = 1'b0;
      end
      S_SEND:  release_s = fire_s & last_s;
      default: release_s = 1'b0;
    endcase
  end

  assign occ_d = occ_q + {1'b0, accept_s} - {1'b0, release_s};
  assign hd_d  = hd_q ^ release_s;
  // The entry becoming head may be the one written at this very edge.
  assign nxt_amt_s = (accept_s && (tail_s == hd_d)) ? bus.PopAmout : amt_q[hd_d];
  assign nxt_go_s  = (occ_d != 2'd0) && (nxt_amt_s != 5'd0);

  // Serializer next-state and beat index
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        k_d = {KW{1'b0}};
        if (nxt_go_s) state_d = S_SEND;
        else          state_d = S_IDLE;
      end
      S_SEND: begin
        if (fire_s && last_s) begin
          k_d = {KW{1'b0}};
          if (nxt_go_s) state_d = S_SEND;
          else          state_d = S_IDLE;
        end else if (fire_s) begin
          k_d     = k_q + KW'(1);
          state_d = S_SEND;
        end else begin
          k_d     = k_q;
          state_d = S_SEND;
        end
      end
      default: begin
        state_d = S_IDLE;
        k_d     = {KW{1'b0}};
      end
    endcase
  end

  // Control state, occupancy and status flags
  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      state_q  <= S_IDLE;
      k_q      <= {KW{1'b0}};
      occ_q    <= 2'd0;
      hd_q     <= 1'b0;
      permit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      occ_q    <= occ_d;
      hd_q     <= hd_d;
      permit_q <= (occ_d < 2'(BUF_DEPTH));
      ovf_q    <= ovf_q | (bus.PopEnable & ~permit_q);
    end
  end

  // Word storage; contents are don't-care while the slot is empty
  always_ff @(posedge i_core_clk) begin
    if (!i_rx_rst && accept_s) begin
      data_q[tail_s] <= bus.PopData;
      amt_q[tail_s]  <= bus.PopAmout;
    end
  end

  // Beat assembly with bytes beyond the word length forced to zero
  always_comb begin
    be_s   = {OUT_BYTES{1'b0}};
    beat_s = {DW{1'b0}};
    for (int j = 0; j < OUT_BYTES; j++) begin
      be_s[j] = valid_s & ((base_s + 6'(j)) < {1'b0, head_amt_s});
      if (be_s[j]) beat_s[8*j +: 8] = shifted_s[8*j +: 8];
      else         beat_s[8*j +: 8] = 8'h00;
    end
  end

  assign bus.o_valid   = valid_s;
  assign bus.o_last    = valid_s & last_s;
  assign bus.o_byte_en = be_s;
  assign bus.o_data    = beat_s;
  assign bus.PopPermit = permit_q;
  assign o_ovf_err     = ovf_q;

`ifdef PFISER_STATS_EN
  function automatic logic [31:0] popcount(input logic [OUT_BYTES-1:0] v);
    logic [31:0] c;
    c = 32'd0;
    for (int i = 0; i < OUT_BYTES; i++) c = c + {31'd0, v[i]};
    return c;
  endfunction

  logic [31:0] cnt_q;

  // Emitted-byte statistic, wraps naturally at 2^32
  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst)    cnt_q <= 32'd0;
    else if (fire_s) cnt_q <= cnt_q + popcount(be_s);
    else             cnt_q <= cnt_q;
  end

  assign o_byte_cnt = cnt_q;
`else
  assign o_byte_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_pfiform_pop_serializer.sv
// Bench for pfiform_pop_serializer: word-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pfiform_pop_serializer;
  localparam int OB = 4;

  logic        i_core_clk = 1'b0;
  logic        i_rx_rst;
  logic        o_ovf_err;
  logic [31:0] o_byte_cnt;

  pfiform_pop_serializer_if #(.OUT_BYTES(OB)) bus ();

  pfiform_pop_serializer #(.OUT_BYTES(OB), .BUF_DEPTH(2)) dut (
    .i_core_clk (i_core_clk),
    .i_rx_rst   (i_rx_rst),
    .bus        (bus),
    .o_ovf_err  (o_ovf_err),
    .o_byte_cnt (o_byte_cnt)
  );

  always #5 i_core_clk = ~i_core_clk;

  typedef struct {
    int           amt;
    logic [255:0] data;
  } word_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          cmp_en = 1'b0;
  word_t       mq[$];
  int          mpos = 0;
  bit          mrst_prev = 1'b1;
  bit          movf = 1'b0;
  logic [31:0] mcnt = 32'd0;
  bit          mon_en = 1'b0;
  int          vcnt, lcnt, first_cyc, last_cyc;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference: words wait in a queue; the head is on the bus whenever it has bytes.
  task automatic model_update();
    bit    permit, present, fire, rel;
    int    nb;
    word_t w;
    if (i_rx_rst) begin
      mq.delete();
      mpos = 0; movf = 1'b0; mcnt = 32'd0; mrst_prev = 1'b1;
    end else begin
      permit  = !mrst_prev && (mq.size() < 2);
      present = (mq.size() > 0) && (mq[0].amt > 0);
      fire    = present && (bus.i_ready === 1'b1);
      rel     = 1'b0;
      if (fire) begin
        nb = mq[0].amt - mpos * OB;
        if (nb > OB) nb = OB;
        mcnt = mcnt + 32'(nb);
        rel  = ((mpos + 1) * OB >= mq[0].amt);
      end else if (!present && mq.size() > 0) begin
        rel = 1'b1;
      end
      if (bus.PopEnable && !permit) movf = 1'b1;
      if (rel) begin
        void'(mq.pop_front());
        mpos = 0;
      end else if (fire) begin
        mpos++;
      end
      if (bus.PopEnable && permit) begin
        w.amt  = int'(bus.PopAmout);
        w.data = bus.PopData;
        mq.push_back(w);
      end
      mrst_prev = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge i_core_clk);
    model_update();
    #1;
  endtask

  function automatic logic [255:0] mk_data(input logic [7:0] base);
    logic [255:0] d;
    for (int i = 0; i < 32; i++) d[8*i +: 8] = base + 8'(i);
    return d;
  endfunction

  task automatic idle_in();
    bus.PopEnable = 1'b0;
    bus.PopAmout  = 5'd0;
    bus.PopData   = 256'd0;
  endtask

  task automatic do_reset();
    i_rx_rst = 1'b1;
    idle_in();
    step();
    step();
    chk("rst_valid", bus.o_valid, 1'b0);
    chk("rst_permit", bus.PopPermit, 1'b0);
    chk("rst_ovf", o_ovf_err, 1'b0);
    chk("rst_cnt", o_byte_cnt, 32'd0);
    i_rx_rst = 1'b0;
    step();
    chk("permit_after_rst", bus.PopPermit, 1'b1);
  endtask

  // Waits (bounded) with PopEnable low for room, then offers the word for one cycle.
  task automatic send_word(input int amt, input logic [255:0] data);
    int waited;
    waited = 0;
    idle_in();
    while (bus.PopPermit !== 1'b1 && waited < 200) begin
      step();
      waited++;
    end
    chk("permit_wait_timeout", (waited < 200), 1'b1);
    bus.PopEnable = 1'b1;
    bus.PopAmout  = 5'(amt);
    bus.PopData   = data;
    step();
    idle_in();
  endtask

  task automatic mon_clear();
    vcnt = 0; lcnt = 0; first_cyc = -1; last_cyc = -1;
  endtask

  // Per-cycle compare of every DUT output against the reference model
  initial begin : compare
    logic               ev, el, ep;
    logic [OB-1:0]      eb;
    logic [8*OB-1:0]    ed;
    logic [31:0]        ec;
    word_t              h;
    int                 idx;
    forever begin
      @(negedge i_core_clk);
      cyc++;
      if (cmp_en) begin
        ev = (mq.size() > 0) && (mq[0].amt > 0);
        eb = '0; ed = '0; el = 1'b0;
        if (ev) begin
          h = mq[0];
          for (int j = 0; j < OB; j++) begin
            idx = mpos * OB + j;
            if (idx < h.amt) begin
              eb[j] = 1'b1;
              ed[8*j +: 8] = h.data[8*idx +: 8];
            end
          end
          el = ((mpos + 1) * OB >= h.amt);
        end
        ep = !mrst_prev && (mq.size() < 2);
`ifdef PFISER_STATS_EN
        ec = mcnt;
`else
        ec = 32'd0;
`endif
        chk("o_valid", bus.o_valid, ev);
        chk("o_data", bus.o_data, ed);
        chk("o_byte_en", bus.o_byte_en, eb);
        chk("o_last", bus.o_last, el);
        chk("PopPermit", bus.PopPermit, ep);
        chk("o_ovf_err", o_ovf_err, movf);
        chk("o_byte_cnt", o_byte_cnt, ec);
      end
      if (mon_en && bus.o_valid === 1'b1) begin
        vcnt++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (bus.o_last === 1'b1 && bus.i_ready === 1'b1) lcnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit go;
    logic [255:0] rd;
    i_rx_rst     = 1'b1;
    bus.i_ready  = 1'b1;
    idle_in();
    step();
    cmp_en = 1'b1;
    do_reset();

    // Single 10-byte word, sink always ready
    send_word(10, mk_data(8'h00));
    chk("a_valid0", bus.o_valid, 1'b1);
    chk("a_data0", bus.o_data, 32'h03020100);
    chk("a_be0", bus.o_byte_en, 4'b1111);
    chk("a_last0", bus.o_last, 1'b0);
    step();
    chk("a_data1", bus.o_data, 32'h07060504);
    chk("a_be1", bus.o_byte_en, 4'b1111);
    step();
    chk("a_data2", bus.o_data, 32'h00000908);
    chk("a_be2", bus.o_byte_en, 4'b0011);
    chk("a_last2", bus.o_last, 1'b1);
    step();
    chk("a_idle", bus.o_valid, 1'b0);

    // Back-to-back 23 and 15 byte words
    mon_clear();
    mon_en = 1'b1;
    send_word(23, mk_data(8'h20));
    send_word(15, mk_data(8'h60));
    repeat (14) step();
    mon_en = 1'b0;
    chk("b_valid_cycles", 32'(vcnt), 32'd10);
    chk("b_last_count", 32'(lcnt), 32'd2);
    chk("b_contiguous", 32'(last_cyc - first_cyc + 1), 32'd10);
`ifdef PFISER_STATS_EN
    chk("b_byte_cnt", o_byte_cnt, 32'd48);
`else
    chk("b_byte_cnt", o_byte_cnt, 32'd0);
`endif

    // Zero-length word between two 10-byte words
    mon_clear();
    mon_en = 1'b1;
    send_word(10, mk_data(8'h10));
    send_word(0, mk_data(8'hEE));
    send_word(10, mk_data(8'h30));
    repeat (20) step();
    mon_en = 1'b0;
    chk("c_last_count", 32'(lcnt), 32'd2);
    chk("c_valid_cycles", 32'(vcnt), 32'd6);
    chk("c_permit", bus.PopPermit, 1'b1);

    // Backpressure: three offers, two fit, the third overflows
    do_reset();
    bus.i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.PopEnable = 1'b1;
      bus.PopAmout  = 5'd12;
      bus.PopData   = mk_data(8'h80 + 8'(32 * k));
      step();
    end
    idle_in();
    chk("d_permit", bus.PopPermit, 1'b0);
    chk("d_ovf", o_ovf_err, 1'b1);
    chk("d_data", bus.o_data, 32'h83828180);
    repeat (3) step();
    chk("d_data_held", bus.o_data, 32'h83828180);
    bus.i_ready = 1'b1;
    repeat (15) step();
    chk("d_ovf_sticky", o_ovf_err, 1'b1);
    chk("d_permit_back", bus.PopPermit, 1'b1);

    // Reset in the middle of a word
    do_reset();
    send_word(10, mk_data(8'h00));
    step();
    i_rx_rst = 1'b1;
    step();
    chk("e_valid", bus.o_valid, 1'b0);
    chk("e_data", bus.o_data, 32'h0);
    chk("e_permit", bus.PopPermit, 1'b0);
    chk("e_ovf", o_ovf_err, 1'b0);
    i_rx_rst = 1'b0;
    step();
    chk("e_permit_after", bus.PopPermit, 1'b1);
    send_word(10, mk_data(8'h40));
    chk("e_new_beat0", bus.o_data, 32'h43424140);
    chk("e_new_be0", bus.o_byte_en, 4'b1111);
    repeat (6) step();

    // Randomized traffic with random backpressure and rare resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.i_ready = ($urandom_range(0, 3) != 0);
      i_rx_rst    = ($urandom_range(0, 599) == 0);
      go = ($urandom_range(0, 2) == 0);
      if (((i / 500) % 2 == 0) && bus.PopPermit !== 1'b1) go = 1'b0;
      for (int b = 0; b < 8; b++) rd[32*b +: 32] = $urandom();
      bus.PopEnable = go;
      bus.PopAmout  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.PopData   = rd;
      step();
    end
    i_rx_rst    = 1'b0;
    bus.i_ready = 1'b1;
    idle_in();
    repeat (60) step();
    chk("r_drained_valid", bus.o_valid, 1'b0);
    chk("r_drained_permit", bus.PopPermit, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
